// File: rtl/risc_cycle_controller.sv
// Eight-phase instruction sequencer for the 8-bit RISC CPU.
// Steps each instruction through fetch, decode, operand fetch, execute and store, and drives the datapath strobes.
module risc_cycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       go,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] alu_op,
  output logic [2:0] phase
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // The low three bits of the eight phase states equal the reported phase index.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_aluop;
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;

  assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_hlt   = (opcode == OP_HLT);
  assign is_skz   = (opcode == OP_SKZ);
  assign is_sto   = (opcode == OP_STO);
  assign is_jmp   = (opcode == OP_JMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INST_ADDR:  state_d = S_INST_FETCH;
      S_INST_FETCH: state_d = S_INST_LOAD;
      S_INST_LOAD:  state_d = S_IDLE;
      S_IDLE:       state_d = S_OP_ADDR;
      S_OP_ADDR:    state_d = is_hlt ? S_HALTED : S_OP_FETCH;
      S_OP_FETCH:   state_d = S_ALU_OP;
      S_ALU_OP:     state_d = S_STORE;
      S_STORE:      state_d = S_INST_ADDR;
      S_HALTED:     state_d = go ? S_INST_ADDR : S_HALTED;
      default:      state_d = S_INST_ADDR;
    endcase
  end

  // Strobes depend only on state, opcode and zero; go affects only the next state.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    case (state_q)
      S_INST_ADDR: begin
        sel = 1'b1;
      end
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      S_OP_FETCH: begin
        rd = is_aluop;
      end
      S_ALU_OP: begin
        // Second increment of SKZ; zero is only consulted in this phase.
        rd     = is_aluop;
        inc_pc = is_skz && zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      S_STORE: begin
        rd     = is_aluop;
        ld_ac  = is_aluop;
        inc_pc = is_jmp;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      S_HALTED: begin
        sel  = 1'b1;
        halt = 1'b1;
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

  assign alu_op = opcode;
  assign phase  = (state_q == S_HALTED) ? 3'd7 : state_q[2:0];

endmodule

// File: tb/tb_risc_cycle_controller.sv
// Self-checking bench for risc_cycle_controller: directed per-opcode scenarios plus random traffic
// against a phase-counter reference model.
module tb_risc_cycle_controller;

  logic       clk;
  logic       rst_n;
  logic [2:0] opcode;
  logic       zero;
  logic       go;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] alu_op;
  logic [2:0] phase;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_phase  = 0;
  bit m_halted = 0;

  logic [14:0] got_v;
  logic [14:0] exp_v;

  risc_cycle_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .opcode (opcode),
    .zero   (zero),
    .go     (go),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .alu_op (alu_op),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,alu_op,phase}, built strobe by strobe.
  function automatic logic [14:0] exp_out(int ph, bit hlt_st, logic [2:0] op, logic z);
    bit aluop;
    bit e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
    int rep;
    aluop  = (op >= 3'd2) && (op <= 3'd5);
    e_sel  = (ph < 4);
    e_rd   = (ph >= 1 && ph <= 3) || (aluop && ph >= 5);
    e_ldir = (ph == 2) || (ph == 3);
    e_inc  = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    e_ldpc = (op == 3'd7) && (ph >= 6);
    e_ldac = aluop && (ph == 7);
    e_wr   = (op == 3'd6) && (ph == 7);
    e_de   = (op == 3'd6) && (ph >= 6);
    e_halt = (op == 3'd0) && (ph == 4);
    rep    = ph;
    if (hlt_st) begin
      {e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de} = '0;
      e_sel  = 1'b1;
      e_halt = 1'b1;
      rep    = 7;
    end
    return {e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt, op, 3'(rep)};
  endfunction

  task automatic drive(input logic [2:0] op, input logic z, input logic g);
    opcode = op;
    zero   = z;
    go     = g;
    #1;
    got_v = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, alu_op, phase};
    exp_v = exp_out(m_phase, m_halted, opcode, zero);
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_halted) begin
      if (go) begin
        m_halted = 0;
        m_phase  = 0;
      end
    end else if (m_phase == 4 && opcode == 3'd0) begin
      m_halted = 1;
    end else begin
      m_phase = (m_phase + 1) % 8;
    end
    #1;
  endtask

  // Bring the sequencer to the start of an instruction (bounded).
  task automatic align();
    for (int i = 0; i < 20 && !(m_phase == 0 && !m_halted); i++) begin
      drive(3'd2, 1'b0, 1'b1);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(3'd2, 1'b0, 1'b0);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_hold got=%h required=%h", got_v, exp_v);
    end
    #3 rst_n = 1'b1;
    m_phase = 0; m_halted = 0;
    for (int i = 0; i < 5; i++) begin
      drive(3'd2, 1'b0, 1'b0);
      tick();
    end
    // Asynchronous reset mid-phase 5 must take effect without a clock edge.
    rst_n = 1'b0;
    #1;
    m_phase = 0; m_halted = 0;
    drive(3'd2, 1'b0, 1'b0);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_async got=%h required=%h", got_v, exp_v);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      drive(3'd2, 1'b0, 1'b0);
      n_cmp++;
      if (phase !== 3'(i) || got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_release phase=%0d required=%0d got=%h required=%h", phase, i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_add();
    logic [8:0] rd_seen;
    align();
    rd_seen = '0;
    for (int i = 0; i < 8; i++) begin
      drive(3'b010, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rd_seen[i] = rd;
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL add ph%0d got=%h required=%h", i, got_v, exp_v);
      end
      tick();
    end
    n_cmp++;
    if (rd_seen[7:0] !== 8'b1110_1110) begin
      n_fail++;
      $display("FAIL add_rd_pattern got=%b required=%b", rd_seen[7:0], 8'b1110_1110);
    end
  endtask

  task automatic test_skz(input logic z6, input logic z5);
    logic inc6;
    align();
    inc6 = 1'bx;
    for (int i = 0; i < 8; i++) begin
      drive(3'b001, (i == 6) ? z6 : (i == 5) ? z5 : 1'($urandom_range(0, 1)), 1'b0);
      if (i == 6) inc6 = inc_pc;
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL skz z=%b ph%0d got=%h required=%h", z6, i, got_v, exp_v);
      end
      tick();
    end
    n_cmp++;
    if (inc6 !== z6) begin
      n_fail++;
      $display("FAIL skz_inc6 zero=%b got=%b required=%b", z6, inc6, z6);
    end
  endtask

  task automatic test_op(input logic [2:0] op, input string name);
    align();
    for (int i = 0; i < 8; i++) begin
      drive(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s ph%0d got=%h required=%h", name, i, got_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_hlt();
    align();
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 1'b0, 1'b0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL hlt_entry ph%0d got=%h required=%h", i, got_v, exp_v);
      end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      n_cmp++;
      if (got_v !== exp_v || halt !== 1'b1 || phase !== 3'd7) begin
        n_fail++;
        $display("FAIL hlt_hold cyc%0d got=%h required=%h", i, got_v, exp_v);
      end
      tick();
    end
    drive(3'b000, 1'b0, 1'b1);
    tick();
    drive(3'b010, 1'b0, 1'b0);
    n_cmp++;
    if (got_v !== exp_v || phase !== 3'd0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_resume got=%h required=%h", got_v, exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc%0d got=%h required=%h", i, got_v, exp_v);
      end
      if (wr === 1'b1 && ld_ir === 1'b1) begin
        n_fail++;
        $display("FAIL wr_ldir_overlap cyc%0d got=1 required=0", i);
      end
      tick();
    end
  endtask

  initial begin
    opcode = 3'b010;
    zero   = 1'b0;
    go     = 1'b0;
    rst_n  = 1'b0;
    test_reset();
    test_add();
    test_skz(1'b1, 1'b0);
    test_skz(1'b0, 1'b1);
    test_op(3'b111, "jmp");
    test_op(3'b110, "sto");
    test_op(3'b011, "and");
    test_op(3'b101, "lda");
    test_hlt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_cycle_controller.md
Name: risc_cycle_controller

Overview:
- Eight-phase instruction sequencer for the 8-bit RISC CPU.
- Walks each instruction through fetch, decode, operand fetch, execute and store.
- Drives the control strobes for the memory address mux, instruction register, program counter, accumulator and bus driver.
- Forwards the decoded opcode to the ALU as its operation select, and consumes the ALU's accumulator-zero flag for SKZ.

Parameters:
- none. The phase count (8) and opcode width (3) are architectural and fixed.

Ports:
- clk     input   1  system clock; all state updates on rising edge
- rst_n   input   1  asynchronous active-low reset
- opcode  input   3  IR[7:5]; HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111
- zero    input   1  accumulator-zero flag (registered ALU SKZ_cmp)
- go      input   1  resume pulse; honoured only in HALTED
- sel     output  1  address mux: 1=PC, 0=IR operand address
- rd      output  1  memory read enable
- ld_ir   output  1  load instruction register
- inc_pc  output  1  increment program counter
- ld_pc   output  1  load PC from IR operand
- ld_ac   output  1  load accumulator from ALU result
- wr      output  1  memory write strobe
- data_e  output  1  drive accumulator onto data bus
- halt    output  1  processor halted indicator
- alu_op  output  3  ALU operation select, equal to opcode
- phase   output  3  current phase index 0..7; 7 also reported while HALTED

Behaviour:
- States: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), HALTED.
- Normal transitions: 0→1→2→3→4→5→6→7→0, one per clock, unconditionally.
- Exception: in OP_ADDR with opcode=HLT, the next state is HALTED (not OP_FETCH).
- HALTED: stays there while go=0; go=1 → INST_ADDR on the next edge.
- Reset (async, any state including HALTED or mid-instruction): state=INST_ADDR immediately. Output values under reset: sel=1, all other strobes 0, phase=0.
- Strobe generation:
  - Outputs are decoded combinationally from state, opcode and zero only; go never reaches an output combinationally.
  - ALUOP means opcode ∈ {ADD, AND, XOR, LDA}.
- Strobes active in each phase (unlisted strobes are 0):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc; halt if opcode=HLT.
  - OP_FETCH: rd if ALUOP.
  - ALU_OP:
    - rd if ALUOP;
    - inc_pc if opcode=SKZ and zero=1;
    - ld_pc if JMP;
    - data_e if STO.
  - STORE:
    - rd and ld_ac if ALUOP;
    - inc_pc and ld_pc if JMP;
    - wr and data_e if STO.
  - HALTED: halt=1, sel=1, all other strobes 0.
- Per-instruction totals:
  - PC is incremented once per instruction in OP_ADDR.
  - A SKZ with zero=1 produces a second increment in ALU_OP.
  - The zero flag is sampled only in ALU_OP; changes in other phases have no effect.
- Latency:
  - Exactly 8 clocks per non-HLT instruction.
  - HLT reaches HALTED 5 clocks after INST_ADDR.
- alu_op tracks opcode in every state.
- wr is never asserted outside STORE.
- ld_ir and wr are never asserted in the same cycle.
- go outside HALTED is ignored.

Test Plan:
- Reset: rst_n=0 asserted mid-phase 5 → phase=0, sel=1, all other strobes 0 without waiting for a clock edge. Release → phases 1,2,3… on successive edges.
- ADD (opcode=010): expected strobes by phase:
  - rd high in phases 1,2,3,5,6,7;
  - ld_ir high in phases 2,3;
  - inc_pc high in phase 4 only;
  - ld_ac high in phase 7 only;
  - wr, ld_pc and data_e never high;
  - alu_op=010.
- SKZ (opcode=001):
  - with zero=1 → inc_pc high in phases 4 and 6;
  - with zero=0 → inc_pc high in phase 4 only;
  - toggling zero in phase 5 does not change phase-6 inc_pc.
- JMP (opcode=111) → ld_pc high in phases 6 and 7; inc_pc high in phases 4 and 7; rd never high in phases 5–7.
- STO (opcode=110) → data_e high in phases 6 and 7; wr high in phase 7 only; ld_ac stays 0.
- HLT (opcode=000):
  - halt high from phase 4 onward; state HALTED; phase holds at 7.
  - Hold go=0 for 10 clocks → no strobes except sel=1 and halt=1.
  - Pulse go=1 → next edge phase=0, halt=0.
  - A go pulse issued during ADD phases has no effect.
